// File: rtl/vga_native_arb.sv
// vga_native_arb: arbitrates one synchronous-read memory between host native slots and display fetch
// Ports: clk/arst_n (sync, active-low); host write strobe hw_*; host read strobe hr_* with
// hr_data/hr_valid; host_busy; sticky err_ovf cleared by err_clr; display disp_req/disp_addr
// with disp_gnt, disp_rdata/disp_rvalid; memory side mem_en/mem_we/mem_addr/mem_wdata/mem_rdata.
// Optional (VGA_NATIVE_ARB_STATS_EN): stats_clr input and 16-bit saturating disp_stall_cnt output.
module vga_native_arb #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              arst_n,
`ifdef VGA_NATIVE_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       disp_stall_cnt,
`endif
  input  logic              hw_en,
  input  logic [ADDR_W-1:0] hw_addr,
  input  logic [DATA_W-1:0] hw_data,
  input  logic              hr_en,
  input  logic [ADDR_W-1:0] hr_addr,
  output logic [DATA_W-1:0] hr_data,
  output logic              hr_valid,
  output logic              host_busy,
  output logic              err_ovf,
  input  logic              err_clr,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {G_NONE, G_DISP, G_HW, G_HR} gnt_t;
  localparam logic [7:0] MW = 8'(MAX_WAIT);
  logic              w_full, r_full, ovf_q, rd_v, rd_host, host_ok, w_take, r_take, w_ovf, r_ovf;
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic [DATA_W-1:0] w_data, hr_hold, disp_hold;
  logic [7:0]        wait_cnt;
  gnt_t              gnt;
  // Grants are forced off while reset is held so every output reads 0 during reset.
  always_comb begin
    host_ok   = !disp_req || wait_cnt == MW;
    gnt       = !arst_n ? G_NONE :
                (w_full && host_ok) ? G_HW :
                (r_full && host_ok) ? G_HR :
                (disp_req && wait_cnt < MW) ? G_DISP : G_NONE;
    w_take    = hw_en && (!w_full || gnt == G_HW);
    r_take    = hr_en && (!r_full || gnt == G_HR);
    w_ovf     = hw_en && w_full && gnt != G_HW;
    r_ovf     = hr_en && r_full && gnt != G_HR;
    mem_en    = gnt != G_NONE;
    mem_we    = gnt == G_HW;
    mem_addr  = gnt == G_HW ? w_addr : gnt == G_HR ? r_addr : gnt == G_DISP ? disp_addr : '0;
    mem_wdata = gnt == G_HW ? w_data : '0;
    disp_gnt  = gnt == G_DISP;
    hr_valid    = arst_n && rd_v && rd_host;
    disp_rvalid = arst_n && rd_v && !rd_host;
    // Read data passes straight through in its valid cycle, then holds.
    hr_data     = !arst_n ? '0 : hr_valid ? mem_rdata : hr_hold;
    disp_rdata  = !arst_n ? '0 : disp_rvalid ? mem_rdata : disp_hold;
    host_busy   = arst_n && (w_full || r_full);
    err_ovf     = arst_n && ovf_q;
  end
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      w_full    <= 1'b0;
      r_full    <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      r_addr    <= '0;
      ovf_q     <= 1'b0;
      wait_cnt  <= '0;
      rd_v      <= 1'b0;
      rd_host   <= 1'b0;
      hr_hold   <= '0;
      disp_hold <= '0;
    end else begin
      w_full <= w_take || (w_full && gnt != G_HW);
      r_full <= r_take || (r_full && gnt != G_HR);
      if (w_take) begin
        w_addr <= hw_addr;
        w_data <= hw_data;
      end
      if (r_take) r_addr <= hr_addr;
      ovf_q    <= w_ovf || r_ovf || (ovf_q && !err_clr);
      wait_cnt <= (gnt == G_HW || gnt == G_HR || (!w_full && !r_full)) ? 8'd0 :
                  wait_cnt == MW ? wait_cnt : wait_cnt + 8'd1;
      rd_v     <= gnt == G_HR || gnt == G_DISP;
      rd_host  <= gnt == G_HR;
      if (hr_valid) hr_hold <= mem_rdata;
      if (disp_rvalid) disp_hold <= mem_rdata;
    end
  end
`ifdef VGA_NATIVE_ARB_STATS_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (!arst_n || stats_clr) stall_q <= '0;
    else if (disp_req && !disp_gnt && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign disp_stall_cnt = arst_n ? stall_q : '0;
`endif
endmodule

// File: tb/tb_vga_native_arb.sv
// tb_vga_native_arb: table vectors, hand sequences and read-data scoreboards for vga_native_arb
module tb_vga_native_arb;
  logic        clk = 1'b0;
  logic        arst_n, hw_en, hr_en, err_clr, disp_req;
  logic [9:0]  hw_addr, hr_addr, disp_addr, mem_addr;
  logic [31:0] hw_data, hr_data, disp_rdata, mem_wdata, mem_rdata;
  logic        hr_valid, host_busy, err_ovf, disp_gnt, disp_rvalid, mem_en, mem_we;
`ifdef VGA_NATIVE_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] disp_stall_cnt;
`endif
  logic [31:0] mem [0:1023];
  logic [31:0] shadow [0:1023];
  logic [31:0] hr_q[$], disp_q[$];
  logic [31:0] he, de;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  vga_native_arb dut (
    .clk(clk), .arst_n(arst_n),
`ifdef VGA_NATIVE_ARB_STATS_EN
    .stats_clr(stats_clr), .disp_stall_cnt(disp_stall_cnt),
`endif
    .hw_en(hw_en), .hw_addr(hw_addr), .hw_data(hw_data),
    .hr_en(hr_en), .hr_addr(hr_addr), .hr_data(hr_data), .hr_valid(hr_valid),
    .host_busy(host_busy), .err_ovf(err_ovf), .err_clr(err_clr),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic neg();
    @(negedge clk);
  endtask
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end
  always @(negedge clk) begin
    if (hr_valid) begin
      he = hr_q.size() != 0 ? hr_q.pop_front() : 32'hBAD0BAD0;
      chk("hr_data", hr_data, he);
    end
    if (disp_rvalid) begin
      de = disp_q.size() != 0 ? disp_q.pop_front() : 32'hBAD0BAD0;
      chk("disp_rdata", disp_rdata, de);
    end
    if (hr_valid || disp_rvalid) chk("rvalid_overlap", 32'(hr_valid & disp_rvalid), 0);
    if (disp_gnt) disp_q.push_back(shadow[disp_addr]);
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] data;
    logic        exp_we;
    logic [9:0]  exp_addr;
    logic        exp_rvalid;
  } vec_t;
  vec_t vt [6];
  initial begin
    int n;
    bit got;
    vt[0] = '{1'b1, 10'h010, 32'hDEADBEEF, 1'b1, 10'h010, 1'b0};
    vt[1] = '{1'b0, 10'h010, 32'h0,        1'b0, 10'h010, 1'b1};
    vt[2] = '{1'b1, 10'h3FF, 32'h12345678, 1'b1, 10'h3FF, 1'b0};
    vt[3] = '{1'b0, 10'h3FF, 32'h0,        1'b0, 10'h3FF, 1'b1};
    vt[4] = '{1'b0, 10'h000, 32'h0,        1'b0, 10'h000, 1'b1};
    vt[5] = '{1'b0, 10'h200, 32'h0,        1'b0, 10'h200, 1'b1};
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h5A000000 | i;
      shadow[i] = 32'h5A000000 | i;
    end
    arst_n = 0; hw_en = 0; hr_en = 0; err_clr = 0; disp_req = 1; disp_addr = 10'h100;
    hw_addr = 0; hw_data = 0; hr_addr = 0;
`ifdef VGA_NATIVE_ARB_STATS_EN
    stats_clr = 0;
`endif
    step; step;
    neg;
    chk("reset_mem_en", mem_en, 0);
    chk("reset_disp_gnt", disp_gnt, 0);
    chk("reset_host_busy", host_busy, 0);
    chk("reset_err_ovf", err_ovf, 0);
    chk("reset_hr_valid", hr_valid, 0);
    step; arst_n = 1; disp_req = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (vt[i].wr) begin
        hw_en = 1; hw_addr = vt[i].addr; hw_data = vt[i].data; shadow[vt[i].addr] = vt[i].data;
      end else begin
        hr_en = 1; hr_addr = vt[i].addr; hr_q.push_back(shadow[vt[i].addr]);
      end
      neg;
      chk("vec_idle_mem_en", mem_en, 0);
      step; hw_en = 0; hr_en = 0;
      neg;
      chk("vec_mem_en", mem_en, 1);
      chk("vec_mem_we", mem_we, vt[i].exp_we);
      chk("vec_mem_addr", mem_addr, vt[i].exp_addr);
      if (vt[i].wr) chk("vec_mem_wdata", mem_wdata, vt[i].data);
      chk("vec_busy", host_busy, 1);
      step;
      neg;
      chk("vec_hr_valid", hr_valid, vt[i].exp_rvalid);
      chk("vec_busy_done", host_busy, 0);
    end
    step; hw_en = 1; hr_en = 1; hw_addr = 10'h005; hr_addr = 10'h005; hw_data = 32'h55AA55AA;
    shadow[5] = 32'h55AA55AA; hr_q.push_back(32'h55AA55AA);
    step; hw_en = 0; hr_en = 0;
    neg;
    chk("same_w_we", mem_we, 1);
    chk("same_w_addr", mem_addr, 10'h005);
    step; neg;
    chk("same_r_en", mem_en, 1);
    chk("same_r_we", mem_we, 0);
    step; neg;
    chk("same_r_valid", hr_valid, 1);
    step; hw_en = 1; hw_addr = 10'h040; hw_data = 32'h11111111; shadow[10'h040] = 32'h11111111;
    step; hw_en = 1; hw_addr = 10'h041; hw_data = 32'h22222222; shadow[10'h041] = 32'h22222222;
    neg;
    chk("refill_first_addr", mem_addr, 10'h040);
    step; hw_en = 0;
    neg;
    chk("refill_second_we", mem_we, 1);
    chk("refill_second_data", mem_wdata, 32'h22222222);
    chk("refill_no_err", err_ovf, 0);
    step; disp_req = 1; disp_addr = 10'h100;
    neg;
    chk("disp_same_cycle_gnt", disp_gnt, 1);
    step; hw_en = 1; hw_addr = 10'h020; hw_data = 32'h13572468; shadow[10'h020] = 32'h13572468;
    step; hw_en = 0;
    n = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      neg;
      if (mem_we) got = 1;
      else begin
        if (disp_gnt) n++;
        step;
      end
    end
    chk("starve_host_granted", 32'(got), 1);
    chk("starve_disp_cycles", n, 8);
    chk("starve_hw_no_disp", disp_gnt, 0);
    chk("starve_hw_addr", mem_addr, 10'h020);
    step; neg;
    chk("starve_disp_resume", disp_gnt, 1);
    step; disp_addr = 10'h101; hw_en = 1; hw_addr = 10'h030; hw_data = 32'hAAAA0001;
    shadow[10'h030] = 32'hAAAA0001;
    step; hw_addr = 10'h031; hw_data = 32'hBBBB0002;
    neg;
    chk("ovf_not_yet", err_ovf, 0);
    step; hw_addr = 10'h030; hw_data = 32'hCCCC0003; err_clr = 1;
    neg;
    chk("ovf_set", err_ovf, 1);
    chk("ovf_busy", host_busy, 1);
    step; hw_en = 0;
    neg;
    chk("ovf_wins_clr", err_ovf, 1);
    step; err_clr = 0;
    neg;
    chk("ovf_cleared", err_ovf, 0);
    step; disp_req = 0;
    neg;
    chk("ovf_drain_we", mem_we, 1);
    chk("ovf_drain_addr", mem_addr, 10'h030);
    chk("ovf_drain_data", mem_wdata, 32'hAAAA0001);
    step; hr_en = 1; hr_addr = 10'h030; hr_q.push_back(shadow[10'h030]);
    step; hr_en = 0;
    step; neg;
    chk("ovf_readback_valid", hr_valid, 1);
    step; hr_en = 1; hr_addr = 10'h010;
    step; hr_en = 0; hw_en = 1; hw_addr = 10'h050; hw_data = 32'hEEEEEEEE;
    neg;
    chk("rst_read_granted", mem_en & ~mem_we, 1);
    step; hw_en = 0; arst_n = 0;
    neg;
    chk("rst_hr_valid", hr_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_hr_data", hr_data, 0);
    chk("rst_busy", host_busy, 0);
    step; arst_n = 1;
    neg;
    chk("rst_after_busy", host_busy, 0);
    chk("rst_after_valid", hr_valid, 0);
    chk("rst_after_mem_en", mem_en, 0);
`ifdef VGA_NATIVE_ARB_STATS_EN
    step; stats_clr = 1;
    step; stats_clr = 0; disp_req = 1; disp_addr = 10'h102;
    for (int e = 0; e < 10; e++) begin
      step; hw_en = 1; hw_addr = 10'h060 + 10'(e); hw_data = 32'(e); shadow[10'h060 + 10'(e)] = 32'(e);
      step; hw_en = 0;
      repeat (10) step;
    end
    disp_req = 0;
    neg;
    chk("stats_count", disp_stall_cnt, 10);
    step; stats_clr = 1;
    step; stats_clr = 0;
    neg;
    chk("stats_clear", disp_stall_cnt, 0);
`endif
    repeat (3) step;
    neg;
    chk("hr_queue_empty", hr_q.size(), 0);
    chk("disp_queue_empty", disp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
